// File: rtl/carbon_fabric_sram_target_if.sv
// carbon_fabric_sram_target_if: request/response bus between a fabric initiator and the SRAM target.
interface carbon_fabric_sram_target_if;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic [2:0]  req_size;
    logic [7:0]  req_attr;
    logic [3:0]  req_id;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [7:0]  rsp_code;
    logic [3:0]  rsp_id;
    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_wstrb, req_size, req_attr, req_id, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_code, rsp_id
    );
    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_wstrb, req_size, req_attr, req_id, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_code, rsp_id
    );
endinterface

// File: rtl/carbon_fabric_sram_target.sv
// carbon_fabric_sram_target: single-outstanding byte-addressed SRAM target with programmable response latency.
module carbon_fabric_sram_target #(
    parameter int          MEM_BYTES    = 4096,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          RESP_LATENCY = 1,
    parameter logic [7:0]  ERR_CODE     = 8'h02
) (
    input logic clk,
    input logic rst_n,
    carbon_fabric_sram_target_if.slave bus
);
    localparam logic [7:0] XACT_READ  = 8'h01;
    localparam logic [7:0] XACT_WRITE = 8'h02;
    localparam logic [7:0] RESP_OK    = 8'h00;
    localparam int         AW         = $clog2(MEM_BYTES);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t      state;
    logic [3:0]  cnt;
    logic [7:0]  mem [MEM_BYTES];
    logic [31:0] offset, aligned, rd;
    logic [AW-1:0] idx;
    logic        accept, is_rd, is_wr, err, unused_ok;
    assign accept  = bus.req_valid && bus.req_ready;
    assign is_rd   = bus.req_op == XACT_READ;
    assign is_wr   = bus.req_op == XACT_WRITE;
    // Modular subtraction makes addresses below BASE_ADDR huge, so they fail the range check.
    assign offset  = bus.req_addr - BASE_ADDR;
    assign aligned = {offset[31:2], 2'b00};
    assign err     = ({1'b0, aligned} + 33'd4 > 33'(MEM_BYTES)) || bus.req_size > 3'd2 || !(is_rd || is_wr);
    assign idx     = aligned[AW-1:0];
    assign rd      = {mem[idx | AW'(3)], mem[idx | AW'(2)], mem[idx | AW'(1)], mem[idx]};
    assign bus.req_ready = state == IDLE && rst_n;
    assign unused_ok = ^{bus.req_attr, offset[1:0]};
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (accept && is_wr && !err && bus.req_wstrb[k]) mem[idx | AW'(k)] <= bus.req_wdata[8*k +: 8];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_code  <= '0;
            bus.rsp_id    <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    state         <= WAIT;
                    cnt           <= 4'(RESP_LATENCY - 1);
                    bus.rsp_id    <= bus.req_id;
                    bus.rsp_code  <= err ? ERR_CODE : RESP_OK;
                    bus.rsp_rdata <= (err || !is_rd) ? 32'd0 : rd;
                end
                WAIT: if (cnt == 4'd0) begin
                    state         <= RESP;
                    bus.rsp_valid <= 1'b1;
                end else cnt <= cnt - 4'd1;
                RESP: if (bus.rsp_ready) begin
                    state         <= IDLE;
                    bus.rsp_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
